// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: decoder branch modes and FSM states.
package fetch_pkg;

  typedef enum logic [2:0] {
    BR_NEXT = 3'd0,
    BR_JEQ  = 3'd1,
    BR_JNE  = 3'd2,
    BR_JMP  = 3'd3,
    BR_CALL = 3'd4,
    BR_RET  = 3'd5,
    BR_HALT = 3'd6,
    BR_RSVD = 3'd7
  } br_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO used by CALL/RET. The caller guards push/pop with full/empty.
module ret_stack #(
  parameter int PCW         = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           push,
  input  logic           pop,
  input  logic           clr,
  input  logic [PCW-1:0] din,
  output logic [PCW-1:0] dout,
  output logic           full,
  output logic           empty
);

  localparam int AW  = $clog2(STACK_DEPTH);
  localparam int SPW = AW + 1;

  logic [PCW-1:0] mem_r [STACK_DEPTH];
  logic [SPW-1:0] sp_r;
  logic [AW-1:0]  wr_idx_s;
  logic [AW-1:0]  rd_idx_s;

  assign wr_idx_s = AW'(sp_r);
  assign rd_idx_s = AW'(sp_r - SPW'(1));
  assign dout     = mem_r[rd_idx_s];
  assign full     = (sp_r == SPW'(STACK_DEPTH));
  assign empty    = (sp_r == SPW'(0));

  // Stack pointer: cleared by reset or clr, otherwise moves on guarded push/pop.
  always_ff @(posedge Clk) begin
    if (Reset || clr) begin
      sp_r <= SPW'(0);
    end else if (push && !full) begin
      sp_r <= sp_r + SPW'(1);
    end else if (pop && !empty) begin
      sp_r <= sp_r - SPW'(1);
    end
  end

  // Entry storage; contents above sp are don't-care so no reset is needed.
  always_ff @(posedge Clk) begin
    if (!Reset && !clr && push && !full) begin
      mem_r[wr_idx_s] <= din;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns PC, Start/Ack handshake, return stack and the
// saturating executed-instruction counter.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int PCW         = 10,
  parameter int OFFW        = 8,
  parameter int STACK_DEPTH = 4,
  parameter int START_ADDR  = 0,
  parameter int CYC_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  br_mode_e         BrMode,
  input  logic [PCW-1:0]   BrTarget,
  input  logic [OFFW-1:0]  BrOffset,
  input  logic             Zero,
  output logic [PCW-1:0]   PC,
  output logic             Running,
  output logic             Ack,
  output logic             Fault,
  output logic [CYC_W-1:0] CycleCt
);

  localparam logic [PCW-1:0] START_PC = PCW'(START_ADDR);

  fsm_state_e       state_r, state_nx;
  logic [PCW-1:0]   pc_r, pc_nx;
  logic             ack_r, ack_nx;
  logic             fault_r, fault_nx;
  logic [CYC_W-1:0] cyc_r, cyc_nx;
  logic             push_s, pop_s, clr_s;
  logic [PCW-1:0]   stk_dout_s;
  logic             stk_full_s, stk_empty_s;
  logic [PCW-1:0]   pc_inc_s, pc_rel_s;

  assign pc_inc_s = pc_r + PCW'(1);
  assign pc_rel_s = pc_r + PCW'($signed(BrOffset));

  ret_stack #(
    .PCW         (PCW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .Clk   (Clk),
    .Reset (Reset),
    .push  (push_s),
    .pop   (pop_s),
    .clr   (clr_s),
    .din   (pc_inc_s),
    .dout  (stk_dout_s),
    .full  (stk_full_s),
    .empty (stk_empty_s)
  );

  // State and output registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      pc_r    <= START_PC;
      ack_r   <= 1'b0;
      fault_r <= 1'b0;
      cyc_r   <= CYC_W'(0);
    end else begin
      state_r <= state_nx;
      pc_r    <= pc_nx;
      ack_r   <= ack_nx;
      fault_r <= fault_nx;
      cyc_r   <= cyc_nx;
    end
  end

  // Next-state, PC mux and stack control; Start overrides everything.
  always_comb begin
    state_nx = state_r;
    pc_nx    = pc_r;
    ack_nx   = ack_r;
    fault_nx = fault_r;
    cyc_nx   = cyc_r;
    push_s   = 1'b0;
    pop_s    = 1'b0;
    clr_s    = 1'b0;
    if (Start) begin
      state_nx = ST_ARMED;
      pc_nx    = START_PC;
      ack_nx   = 1'b0;
      fault_nx = 1'b0;
      cyc_nx   = CYC_W'(0);
      clr_s    = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE:  state_nx = ST_IDLE;
        ST_ARMED: state_nx = ST_RUN;
        ST_RUN: begin
          cyc_nx = (cyc_r == {CYC_W{1'b1}}) ? cyc_r : cyc_r + CYC_W'(1);
          case (BrMode)
            BR_JEQ:  pc_nx = Zero ? pc_rel_s : pc_inc_s;
            BR_JNE:  pc_nx = Zero ? pc_inc_s : pc_rel_s;
            BR_JMP:  pc_nx = BrTarget;
            BR_CALL: begin
              if (stk_full_s) begin
                fault_nx = 1'b1;
                ack_nx   = 1'b1;
                state_nx = ST_DONE;
              end else begin
                push_s = 1'b1;
                pc_nx  = BrTarget;
              end
            end
            BR_RET: begin
              if (stk_empty_s) begin
                fault_nx = 1'b1;
                ack_nx   = 1'b1;
                state_nx = ST_DONE;
              end else begin
                pop_s = 1'b1;
                pc_nx = stk_dout_s;
              end
            end
            BR_HALT: begin
              ack_nx   = 1'b1;
              state_nx = ST_DONE;
            end
            default: pc_nx = pc_inc_s;
          endcase
        end
        ST_DONE:  state_nx = ST_DONE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  assign PC      = pc_r;
  assign Running = (state_r == ST_RUN);
  assign Ack     = ack_r;
  assign Fault   = fault_r;
  assign CycleCt = cyc_r;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq; a second instance with CYC_W=4 shares the
// stimulus to observe counter saturation.
module tb_fetch_seq;
  import fetch_pkg::*;

  logic        Clk;
  logic        Reset;
  logic        Start;
  br_mode_e    BrMode;
  logic [9:0]  BrTarget;
  logic [7:0]  BrOffset;
  logic        Zero;
  logic [9:0]  PC;
  logic        Running, Ack, Fault;
  logic [15:0] CycleCt;
  logic [9:0]  pc4;
  logic        run4, ack4, fault4;
  logic [3:0]  cyc4;

  int n_chk = 0;
  int n_err = 0;

  fetch_seq dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BrMode(BrMode),
    .BrTarget(BrTarget), .BrOffset(BrOffset), .Zero(Zero),
    .PC(PC), .Running(Running), .Ack(Ack), .Fault(Fault), .CycleCt(CycleCt)
  );

  fetch_seq #(.CYC_W(4)) dut4 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BrMode(BrMode),
    .BrTarget(BrTarget), .BrOffset(BrOffset), .Zero(Zero),
    .PC(pc4), .Running(run4), .Ack(ack4), .Fault(fault4), .CycleCt(cyc4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic instr(input br_mode_e m, input logic [9:0] tgt, input logic [7:0] off, input logic z);
    BrMode = m; BrTarget = tgt; BrOffset = off; Zero = z;
    tick();
  endtask

  task automatic start_pulse();
    Start = 1'b1; tick();
    Start = 1'b0; tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; Start = 1'b0; BrMode = BR_NEXT;
    BrTarget = 10'd0; BrOffset = 8'd0; Zero = 1'b0;
    tick(); tick();
    Reset = 1'b0; tick();
    check("rst_pc", PC, 32'd0);
    check("rst_run", Running, 32'd0);
    check("rst_ack", Ack, 32'd0);
    check("rst_fault", Fault, 32'd0);
    check("rst_cyc", CycleCt, 32'd0);

    // Start held two cycles, then release
    Start = 1'b1; tick(); tick();
    check("armed_pc", PC, 32'd0);
    check("armed_run", Running, 32'd0);
    Start = 1'b0; tick();
    check("run1_run", Running, 32'd1);
    check("run1_pc", PC, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      instr(BR_NEXT, 10'd0, 8'd0, 1'b0);
      check("next_pc", PC, i);
    end
    check("next_cyc", CycleCt, 32'd5);
    check("next_ack", Ack, 32'd0);
    check("next_cyc4", cyc4, 32'd5);

    // Relative branches
    instr(BR_JMP, 10'd8, 8'd0, 1'b0);
    check("jmp_pc", PC, 32'd8);
    instr(BR_JEQ, 10'd0, 8'hFD, 1'b1);
    check("jeq_taken", PC, 32'd5);
    instr(BR_JNE, 10'd0, 8'd4, 1'b1);
    check("jne_not", PC, 32'd6);
    instr(BR_JEQ, 10'd0, 8'hFD, 1'b0);
    check("jeq_not", PC, 32'd7);
    instr(BR_JNE, 10'd0, 8'd4, 1'b0);
    check("jne_taken", PC, 32'd11);
    instr(BR_JEQ, 10'd0, 8'd0, 1'b1);
    check("self_loop", PC, 32'd11);
    check("br_cyc", CycleCt, 32'd11);

    // CALL / RET
    instr(BR_JMP, 10'h010, 8'd0, 1'b0);
    instr(BR_CALL, 10'h200, 8'd0, 1'b0);
    check("call_pc", PC, 32'h200);
    instr(BR_RET, 10'd0, 8'd0, 1'b0);
    check("ret_pc", PC, 32'h011);
    check("ret_fault", Fault, 32'd0);

    // Overflow on the 5th nested CALL
    for (int i = 0; i < 4; i++) instr(BR_CALL, 10'h100, 8'd0, 1'b0);
    check("call4_pc", PC, 32'h100);
    check("call4_fault", Fault, 32'd0);
    instr(BR_CALL, 10'h2AA, 8'd0, 1'b0);
    check("ovf_pc", PC, 32'h100);
    check("ovf_fault", Fault, 32'd1);
    check("ovf_ack", Ack, 32'd1);
    check("ovf_run", Running, 32'd0);
    check("ovf_cyc", CycleCt, 32'd19);
    check("sat_cyc4", cyc4, 32'd15);
    check("sat_pc4", pc4, 32'h100);
    check("sat_ack4", ack4, 32'd1);
    check("sat_fault4", fault4, 32'd1);
    check("sat_run4", run4, 32'd0);
    instr(BR_NEXT, 10'd0, 8'd0, 1'b0);
    check("done_pc", PC, 32'h100);
    check("done_cyc", CycleCt, 32'd19);
    check("done_ack", Ack, 32'd1);

    // Start clears; RET on empty stack faults
    Start = 1'b1; tick();
    check("restart_ack", Ack, 32'd0);
    check("restart_fault", Fault, 32'd0);
    check("restart_cyc", CycleCt, 32'd0);
    check("restart_pc", PC, 32'd0);
    Start = 1'b0; tick();
    instr(BR_RET, 10'd0, 8'd0, 1'b0);
    check("unf_fault", Fault, 32'd1);
    check("unf_ack", Ack, 32'd1);
    check("unf_pc", PC, 32'd0);
    check("unf_cyc", CycleCt, 32'd1);

    // HALT at top of address space
    start_pulse();
    instr(BR_NEXT, 10'd0, 8'd0, 1'b0);
    instr(BR_JMP, 10'h3FF, 8'd0, 1'b0);
    instr(BR_HALT, 10'd0, 8'd0, 1'b0);
    check("halt_ack", Ack, 32'd1);
    check("halt_pc", PC, 32'h3FF);
    check("halt_cyc", CycleCt, 32'd3);
    check("halt_fault", Fault, 32'd0);
    instr(BR_NEXT, 10'd0, 8'd0, 1'b0);
    check("halt_hold", PC, 32'h3FF);
    Start = 1'b1; tick();
    check("halt_rst_ack", Ack, 32'd0);
    check("halt_rst_cyc", CycleCt, 32'd0);
    check("halt_rst_pc", PC, 32'd0);
    Start = 1'b0; tick();

    // Wrap, then Start concurrent with HALT
    instr(BR_JMP, 10'h3FF, 8'd0, 1'b0);
    instr(BR_NEXT, 10'd0, 8'd0, 1'b0);
    check("wrap_pc", PC, 32'd0);
    instr(BR_JMP, 10'h3FF, 8'd0, 1'b0);
    Start = 1'b1;
    instr(BR_HALT, 10'd0, 8'd0, 1'b0);
    check("st_halt_ack", Ack, 32'd0);
    check("st_halt_run", Running, 32'd0);
    check("st_halt_pc", PC, 32'd0);
    Start = 1'b0;
    instr(BR_NEXT, 10'd0, 8'd0, 1'b0);
    check("st_halt_run2", Running, 32'd1);
    check("st_halt_ack2", Ack, 32'd0);

    // Reset mid-RUN during a CALL leaves no stacked entry
    instr(BR_NEXT, 10'd0, 8'd0, 1'b0);
    Reset = 1'b1; BrMode = BR_CALL; BrTarget = 10'h155; tick();
    Reset = 1'b0;
    check("mid_rst_pc", PC, 32'd0);
    check("mid_rst_run", Running, 32'd0);
    check("mid_rst_cyc", CycleCt, 32'd0);
    BrMode = BR_NEXT; tick();
    check("mid_rst_idle", Running, 32'd0);
    start_pulse();
    instr(BR_RET, 10'd0, 8'd0, 1'b0);
    check("mid_rst_unf", Fault, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
